// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU built-in self-test: op codes, FSM encoding
// and the layout of one test vector.
package alu_bist_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [3:0] NO_FAIL_INDEX = 4'hF;
    localparam logic [3:0] FAIL_COUNT_MAX = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } bist_state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] result;
    } vector_t;

    // Flags the ALU must report for a given result: {ZR, NG}.
    function automatic logic [1:0] expected_flags(input logic [31:0] result);
        return {(result == 32'd0), result[31]};
    endfunction

endpackage

// File: rtl/alu_bist_rom.sv
// Fixed ALU test-vector table; a combinational index-to-record lookup kept
// apart from the controller so the table can be swapped independently.
module alu_bist_rom
    import alu_bist_pkg::*;
(
    input  logic [3:0] index,
    output vector_t    vector
);

    // Table lookup; unused indices return an all-zero AND vector.
    always_comb begin
        vector = '{OP_AND, 32'd0, 32'd0, 32'd0};
        case (index)
            4'd0:    vector = '{OP_ADD, 32'd2565, 32'd1560, 32'h0000101D};
            4'd1:    vector = '{OP_AND, 32'd2565, 32'd1560, 32'h00000200};
            4'd2:    vector = '{OP_SUB, 32'd2565, 32'd1560, 32'h000003ED};
            4'd3:    vector = '{OP_OR,  32'd2565, 32'd1560, 32'h00000E1D};
            4'd4:    vector = '{OP_NOR, 32'd2565, 32'd1560, 32'hFFFFF1E2};
            4'd5:    vector = '{OP_SLT, 32'd2565, 32'd1560, 32'h00000000};
            4'd6:    vector = '{OP_SLT, 32'd1560, 32'd2565, 32'h00000001};
            4'd7:    vector = '{OP_SUB, 32'd1560, 32'd1560, 32'h00000000};
            4'd8:    vector = '{OP_SUB, 32'd1560, 32'd2565, 32'hFFFFFC13};
            default: vector = '{OP_AND, 32'd0, 32'd0, 32'd0};
        endcase
    end

endmodule

// File: rtl/alu_bist.sv
// ALU self-test controller: walks the vector table, drives the ALU, waits for
// it to settle, then checks result and flags and accumulates a verdict.
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int STOP_ON_FAIL  = 0,
    parameter int NUM_VECTORS   = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [3:0]  alu_operation,
    output logic [31:0] alu_in_x,
    output logic [31:0] alu_in_y,
    input  logic [31:0] alu_out_s,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_count,
    output logic [3:0]  first_fail_index
);

    localparam logic [3:0] LAST_INDEX  = 4'(NUM_VECTORS - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    bist_state_t state;
    bist_state_t state_next;
    logic [3:0]  index;
    logic [3:0]  wait_count;
    vector_t     vec;
    logic        mismatch;
    logic        halt;
    logic [3:0]  fail_count_inc;

    alu_bist_rom u_rom (
        .index  (index),
        .vector (vec)
    );

    // Compare the sampled ALU outputs with the current table entry.
    always_comb begin
        mismatch = (alu_out_s != vec.result) ||
                   ({alu_zr, alu_ng} != expected_flags(vec.result));
        halt     = (index == LAST_INDEX) || ((STOP_ON_FAIL != 0) && mismatch);
        if (fail_count == FAIL_COUNT_MAX) begin
            fail_count_inc = fail_count;
        end else begin
            fail_count_inc = fail_count + 4'd1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_DRIVE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_DRIVE: state_next = ST_SETTLE;
            ST_SETTLE: begin
                if (wait_count == SETTLE_LAST) begin
                    state_next = ST_CHECK;
                end else begin
                    state_next = ST_SETTLE;
                end
            end
            ST_CHECK: begin
                if (halt) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_DRIVE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and registered outputs; busy/done follow the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            index            <= 4'd0;
            wait_count       <= 4'd0;
            alu_operation    <= OP_AND;
            alu_in_x         <= 32'd0;
            alu_in_y         <= 32'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            fail_count       <= 4'd0;
            first_fail_index <= NO_FAIL_INDEX;
        end else begin
            busy <= (state_next != ST_IDLE);
            done <= (state_next == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        index            <= 4'd0;
                        fail_count       <= 4'd0;
                        first_fail_index <= NO_FAIL_INDEX;
                        pass             <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    alu_operation <= vec.op;
                    alu_in_x      <= vec.a;
                    alu_in_y      <= vec.b;
                    wait_count    <= 4'd0;
                end
                ST_SETTLE: wait_count <= wait_count + 4'd1;
                ST_CHECK: begin
                    if (mismatch) begin
                        fail_count <= fail_count_inc;
                        if (first_fail_index == NO_FAIL_INDEX) begin
                            first_fail_index <= index;
                        end
                    end
                    // The verdict must include the check being retired now.
                    if (halt) begin
                        pass <= (fail_count == 4'd0) && !mismatch;
                    end else begin
                        index <= index + 4'd1;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: three instances (default, stop-on-fail,
// long settle) driven by a faultable ALU model and a cycle-level reference.
module tb_alu_bist;

    localparam int NI = 3;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic        busy;
        logic        done;
        logic        pass;
        logic [3:0]  fc;
        logic [3:0]  ff;
    } obs_t;

    logic        clk;
    logic        rst_n_w [NI];
    logic        start_w [NI];
    logic [3:0]  op_w    [NI];
    logic [31:0] x_w     [NI];
    logic [31:0] y_w     [NI];
    logic [31:0] res_w   [NI];
    logic        zr_w    [NI];
    logic        ng_w    [NI];
    logic        busy_w  [NI];
    logic        done_w  [NI];
    logic        pass_w  [NI];
    logic [3:0]  fc_w    [NI];
    logic [3:0]  ff_w    [NI];

    int fault_mode = 0;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    logic [3:0]  tb_op  [9] = '{4'b0010, 4'b0000, 4'b0110, 4'b0001, 4'b1100,
                                4'b0111, 4'b0111, 4'b0110, 4'b0110};
    logic [31:0] tb_a   [9] = '{32'd2565, 32'd2565, 32'd2565, 32'd2565, 32'd2565,
                                32'd2565, 32'd1560, 32'd1560, 32'd1560};
    logic [31:0] tb_b   [9] = '{32'd1560, 32'd1560, 32'd1560, 32'd1560, 32'd1560,
                                32'd1560, 32'd2565, 32'd1560, 32'd2565};
    logic [31:0] tb_res [9] = '{32'h0000101D, 32'h00000200, 32'h000003ED, 32'h00000E1D,
                                32'hFFFFF1E2, 32'h00000000, 32'h00000001, 32'h00000000,
                                32'hFFFFFC13};

    // Reference state per instance
    bit          valid     [NI];
    bit          has_run   [NI];
    int          start_cyc [NI];
    int          run_l     [NI];
    bit          run_mis   [NI][9];
    logic [3:0]  prev_op   [NI];
    logic [31:0] prev_x    [NI];
    logic [31:0] prev_y    [NI];

    function automatic int settle_of(input int g);
        return (g == 2) ? 3 : 1;
    endfunction

    // ALU with optional injected faults; returns {zr, ng, result}.
    function automatic logic [33:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input int fault);
        logic [31:0] r;
        logic zr;
        logic ng;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
            default: r = 32'd0;
        endcase
        if (fault == 1 && op == 4'b0000) r = 32'h00000201;
        if (fault == 3) r = 32'd0;
        zr = (r == 32'd0);
        ng = r[31];
        if (fault == 2) ng = 1'b0;
        return {zr, ng, r};
    endfunction

    // What instance g must show after posedge number c.
    function automatic obs_t expect_obs(input int g, input int c);
        obs_t e;
        int n, p, l, d, k, fc, ff;
        e = '{4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'hF};
        if (has_run[g]) begin
            n = c - start_cyc[g];
            p = settle_of(g) + 2;
            l = run_l[g];
            d = (l + 1) * p;
            if (n == 0) begin
                e.op = prev_op[g];
                e.x  = prev_x[g];
                e.y  = prev_y[g];
            end else begin
                k = (n - 1) / p;
                if (k > l) k = l;
                e.op = tb_op[k];
                e.x  = tb_a[k];
                e.y  = tb_b[k];
            end
            fc = 0;
            ff = 15;
            for (int j = 0; j <= l; j++) begin
                if ((j + 1) * p <= n && run_mis[g][j]) begin
                    if (fc < 15) fc++;
                    if (ff == 15) ff = j;
                end
            end
            e.busy = (n <= d);
            e.done = (n == d);
            e.pass = (n >= d) && (fc == 0);
            e.fc   = 4'(fc);
            e.ff   = 4'(ff);
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        alu_bist #(
            .SETTLE_CYCLES ((g == 2) ? 3 : 1),
            .STOP_ON_FAIL  ((g == 1) ? 1 : 0),
            .NUM_VECTORS   (9)
        ) u_dut (
            .clk              (clk),
            .reset            (rst_n_w[g]),
            .start            (start_w[g]),
            .alu_operation    (op_w[g]),
            .alu_in_x         (x_w[g]),
            .alu_in_y         (y_w[g]),
            .alu_out_s        (res_w[g]),
            .alu_zr           (zr_w[g]),
            .alu_ng           (ng_w[g]),
            .busy             (busy_w[g]),
            .done             (done_w[g]),
            .pass             (pass_w[g]),
            .fail_count       (fc_w[g]),
            .first_fail_index (ff_w[g])
        );
        assign {zr_w[g], ng_w[g], res_w[g]} = alu_model(op_w[g], x_w[g], y_w[g], fault_mode);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference update at every active edge
    initial begin
        obs_t cur;
        logic [33:0] r;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            for (int g = 0; g < NI; g++) begin
                if (!rst_n_w[g]) begin
                    has_run[g] = 1'b0;
                    valid[g]   = 1'b1;
                end else if (valid[g] && start_w[g]) begin
                    cur = expect_obs(g, cyc - 1);
                    if (!cur.busy) begin
                        prev_op[g]   = cur.op;
                        prev_x[g]    = cur.x;
                        prev_y[g]    = cur.y;
                        has_run[g]   = 1'b1;
                        start_cyc[g] = cyc;
                        run_l[g]     = 8;
                        for (int j = 8; j >= 0; j--) begin
                            r = alu_model(tb_op[j], tb_a[j], tb_b[j], fault_mode);
                            run_mis[g][j] = (r != {(tb_res[j] == 32'd0), tb_res[j][31], tb_res[j]});
                            if (g == 1 && run_mis[g][j]) run_l[g] = j;
                        end
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the reference
    initial begin
        obs_t a;
        forever begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                if (valid[g]) begin
                    a = '{op_w[g], x_w[g], y_w[g], busy_w[g], done_w[g], pass_w[g], fc_w[g], ff_w[g]};
                    check($sformatf("cycle%0d_dut%0d", cyc, g), 128'(a), 128'(expect_obs(g, cyc)));
                end
            end
        end
    end

    task automatic run_and_wait(input int g, output int offs);
        int s;
        offs = -1;
        @(negedge clk);
        start_w[g] = 1'b1;
        @(negedge clk);
        start_w[g] = 1'b0;
        s = cyc;
        for (int i = 0; i < 200; i++) begin
            if (done_w[g]) begin
                offs = cyc - s;
                break;
            end
            @(negedge clk);
        end
        if (offs < 0) check("done_timeout", 128'd1, 128'd0);
    endtask

    task automatic check_result(input string name, input int g, input int offs, input int exp_offs,
                                input logic exp_pass, input logic [3:0] exp_fc, input logic [3:0] exp_ff);
        check({name, "_done_at"}, 128'(offs), 128'(exp_offs));
        check({name, "_pass"}, 128'(pass_w[g]), 128'(exp_pass));
        check({name, "_fail_count"}, 128'(fc_w[g]), 128'(exp_fc));
        check({name, "_first_fail"}, 128'(ff_w[g]), 128'(exp_ff));
    endtask

    initial begin
        logic [33:0] gold;
        int offs, s, dcount;
        bit seen;
        for (int g = 0; g < NI; g++) begin
            rst_n_w[g] = 1'b0;
            start_w[g] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("reset_values", 128'({op_w[0], x_w[0], y_w[0], busy_w[0], done_w[0], pass_w[0], fc_w[0], ff_w[0]}),
              128'({4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'hF}));
        for (int g = 0; g < NI; g++) rst_n_w[g] = 1'b1;

        // Golden ALU against the literal table
        for (int j = 0; j < 9; j++) begin
            gold = alu_model(tb_op[j], tb_a[j], tb_b[j], 0);
            check($sformatf("golden_vec%0d", j), 128'(gold),
                  128'({(tb_res[j] == 32'd0), tb_res[j][31], tb_res[j]}));
        end

        fault_mode = 0;
        run_and_wait(0, offs);
        check_result("good", 0, offs, 27, 1'b1, 4'd0, 4'hF);
        repeat (3) @(negedge clk);
        check("good_busy_after", 128'(busy_w[0]), 128'd0);

        fault_mode = 1;
        run_and_wait(0, offs);
        check_result("and_fault", 0, offs, 27, 1'b0, 4'd1, 4'd1);
        repeat (3) @(negedge clk);

        fault_mode = 2;
        run_and_wait(1, offs);
        check_result("ng_stop", 1, offs, 15, 1'b0, 4'd1, 4'd4);
        check("ng_stop_hold_op", 128'(op_w[1]), 128'(4'b1100));
        repeat (3) @(negedge clk);

        // Reset during SETTLE of vector 3
        fault_mode = 0;
        @(negedge clk);
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        s = cyc;
        repeat (10) @(negedge clk);
        check("pre_reset_vec3", 128'({busy_w[0], op_w[0], x_w[0]}), 128'({1'b1, 4'b0001, 32'd2565}));
        rst_n_w[0] = 1'b0;
        @(negedge clk);
        check("abort_reset_values", 128'({op_w[0], x_w[0], y_w[0], busy_w[0], done_w[0], pass_w[0], fc_w[0], ff_w[0]}),
              128'({4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'hF}));
        rst_n_w[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_w[0]) seen = 1'b1;
        end
        check("abort_no_done", 128'(seen), 128'd0);
        run_and_wait(0, offs);
        check_result("after_abort", 0, offs, 27, 1'b1, 4'd0, 4'hF);
        repeat (3) @(negedge clk);

        // Long settle with start re-pulsed while busy (including during DONE)
        @(negedge clk);
        start_w[2] = 1'b1;
        @(negedge clk);
        start_w[2] = 1'b0;
        s = cyc;
        dcount = 0;
        offs = -1;
        for (int i = 0; i < 70; i++) begin
            start_w[2] = ((cyc - s) == 5 || (cyc - s) == 20 || (cyc - s) == 45);
            if (done_w[2]) begin
                dcount++;
                if (offs < 0) offs = cyc - s;
            end
            @(negedge clk);
        end
        start_w[2] = 1'b0;
        check("settle3_done_at", 128'(offs), 128'd45);
        check("settle3_single_done", 128'(dcount), 128'd1);
        check("settle3_pass", 128'(pass_w[2]), 128'd1);

        fault_mode = 3;
        run_and_wait(0, offs);
        check_result("zero_result", 0, offs, 27, 1'b0, 4'd7, 4'd0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
